// File: rtl/iopmp_err_report_tlul_if.sv
// rtl/iopmp_err_report_tlul_if.sv - TL-UL A/D channel bundle for the IOPMP error-report port
// Purpose: groups the TL-UL host request (A channel, d_ready) and device
// response (a_ready, D channel) signals of one 32-bit TL-UL link.
// Modports:
//   master : host side, drives a_* and d_ready
//   slave  : device side, drives a_ready and d_*
// Opcodes: Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1.
interface iopmp_err_report_tlul_if #(
  parameter int SourceWidth = 8
);
  logic                   a_valid;
  logic [2:0]             a_opcode;
  logic [31:0]            a_address;
  logic [3:0]             a_mask;
  logic [31:0]            a_data;
  logic [SourceWidth-1:0] a_source;
  logic [1:0]             a_size;
  logic                   d_ready;

  logic                   a_ready;
  logic                   d_valid;
  logic [2:0]             d_opcode;
  logic [31:0]            d_data;
  logic [SourceWidth-1:0] d_source;
  logic [1:0]             d_size;
  logic                   d_error;

  modport master (
    output a_valid, a_opcode, a_address, a_mask, a_data, a_source, a_size, d_ready,
    input  a_ready, d_valid, d_opcode, d_data, d_source, d_size, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_address, a_mask, a_data, a_source, a_size, d_ready,
    output a_ready, d_valid, d_opcode, d_data, d_source, d_size, d_error
  );
endinterface

// File: rtl/iopmp_err_report_tlul.sv
// rtl/iopmp_err_report_tlul.sv - IOPMP error-capture registers behind a TL-UL device port
// Purpose: records the first denied IOPMP access (address, access type, RRID),
// raises irq_o = ie & v and lets the host read/clear the record over TL-UL.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tl              TL-UL device port (slave modport), one outstanding transaction
//   viol_valid_i    per-channel one-cycle denied-access pulse
//   viol_addr_i     per-channel 34-bit denied address
//   viol_access_i   per-channel access type (1 = read, 2 = write)
//   irq_o           error interrupt, registered
// Registers: 0x00 ERR_CFG, 0x04 ERR_INFO, 0x08 ERR_REQADDR, 0x0C ERR_REQID, 0x10 ERR_CNT.
// Build option: define IOPMP_ERR_CNT_EN to implement the ERR_CNT counter;
// otherwise ERR_CNT reads as 0 and has no flops.
module iopmp_err_report_tlul #(
  parameter int IOPMPNumChan = 2,
  parameter int SourceWidth  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  iopmp_err_report_tlul_if.slave       tl,
  input  logic [IOPMPNumChan-1:0]      viol_valid_i,
  input  logic [IOPMPNumChan-1:0][33:0] viol_addr_i,
  input  logic [IOPMPNumChan-1:0][1:0] viol_access_i,
  output logic                         irq_o
);
  localparam logic [1:0] AccWrite = 2'd2;
  localparam logic [2:0] OpGet = 3'd4, OpPutFull = 3'd0, OpPutPartial = 3'd1;
  localparam logic [2:0] OpAccessAck = 3'd0, OpAccessAckData = 3'd1;

  typedef enum logic {S_IDLE, S_RESP} state_e;
  state_e state_q, state_n;

  logic                   ie_q, v_q, irq_q;
  logic [1:0]             ttype_q;
  logic [31:0]            addr_q;
  logic [SourceWidth-1:0] rrid_q;
  logic [15:0]            cnt_rd;

  logic [2:0]             d_opcode_q;
  logic [31:0]            d_data_q;
  logic [SourceWidth-1:0] d_source_q;
  logic [1:0]             d_size_q;
  logic                   d_error_q;

  // Request decode
  logic acc, is_get, is_put, ro_tgt, req_err, wr_ok, clr, ie_n, v_n;
  logic [31:0] rdata, rsp_data;

  assign acc    = tl.a_valid & tl.a_ready;
  assign is_get = (tl.a_opcode == OpGet);
  assign is_put = (tl.a_opcode == OpPutFull) || (tl.a_opcode == OpPutPartial);
  assign ro_tgt = (tl.a_address == 32'h08) || (tl.a_address == 32'h0C) ||
                  (tl.a_address == 32'h10);
  assign req_err = (tl.a_address[1:0] != 2'b00) || (tl.a_address > 32'h10) ||
                   !(is_get || is_put) ||
                   (is_put && ((tl.a_mask != 4'hF) || ro_tgt));
  assign wr_ok  = acc & is_put & ~req_err;
  assign clr    = wr_ok && (tl.a_address == 32'h04) && tl.a_data[0];

  always_comb begin
    rdata = 32'h0;
    case (tl.a_address[4:2])
      3'd0:    rdata = {31'h0, ie_q};
      3'd1:    rdata = {29'h0, ttype_q, v_q};
      3'd2:    rdata = addr_q;
      3'd3:    rdata = 32'(rrid_q);
      3'd4:    rdata = {16'h0, cnt_rd};
      default: rdata = 32'h0;
    endcase
  end
  assign rsp_data = (is_get && !req_err) ? rdata : 32'h0;

  // Lowest-index violation wins: scan downward so the last hit is the lowest.
  logic                   any_viol, cap;
  logic [SourceWidth-1:0] win_idx;
  logic [33:0]            win_addr;
  logic [1:0]             win_ttype;

  always_comb begin
    win_idx   = '0;
    win_addr  = '0;
    win_ttype = 2'd1;
    for (int i = IOPMPNumChan - 1; i >= 0; i--) begin
      if (viol_valid_i[i]) begin
        win_idx   = SourceWidth'(i);
        win_addr  = viol_addr_i[i];
        win_ttype = (viol_access_i[i] == AccWrite) ? 2'd2 : 2'd1;
      end
    end
  end

  assign any_viol = |viol_valid_i;
  // A clear in the same cycle as a violation re-arms capture, so capture wins.
  assign cap  = any_viol & (~v_q | clr);
  assign v_n  = cap ? 1'b1 : (clr ? 1'b0 : v_q);
  assign ie_n = (wr_ok && (tl.a_address == 32'h00)) ? tl.a_data[0] : ie_q;

  // Response FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Response FSM: next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (tl.a_valid) state_n = S_RESP;
      S_RESP:  if (tl.d_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Response FSM: outputs
  always_comb begin
    tl.a_ready = (state_q == S_IDLE);
    tl.d_valid = (state_q == S_RESP);
  end

  // Register file, capture record and response holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q       <= 1'b0;
      v_q        <= 1'b0;
      irq_q      <= 1'b0;
      ttype_q    <= 2'd0;
      addr_q     <= 32'h0;
      rrid_q     <= '0;
      d_opcode_q <= 3'd0;
      d_data_q   <= 32'h0;
      d_source_q <= '0;
      d_size_q   <= 2'd0;
      d_error_q  <= 1'b0;
    end else begin
      ie_q  <= ie_n;
      v_q   <= v_n;
      irq_q <= ie_n & v_n;
      if (cap) begin
        ttype_q <= win_ttype;
        addr_q  <= win_addr[33:2];
        rrid_q  <= win_idx;
      end
      if (acc) begin
        d_opcode_q <= is_get ? OpAccessAckData : OpAccessAck;
        d_data_q   <= rsp_data;
        d_source_q <= tl.a_source;
        d_size_q   <= tl.a_size;
        d_error_q  <= req_err;
      end
    end
  end

`ifdef IOPMP_ERR_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                              cnt_q <= 16'h0;
    else if (any_viol && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'h1;
  end
  assign cnt_rd = cnt_q;
`else
  assign cnt_rd = 16'h0;
`endif

  assign tl.d_opcode = d_opcode_q;
  assign tl.d_data   = d_data_q;
  assign tl.d_source = d_source_q;
  assign tl.d_size   = d_size_q;
  assign tl.d_error  = d_error_q;
  assign irq_o       = irq_q;

  logic unused_bits;
  assign unused_bits = ^{win_addr[1:0], tl.a_data[31:1]};
endmodule
